morse_word_scheduler: RTL and testbench
=======================================

// Module: morse_word_scheduler
// PURPOSE
//  Controller between the Morse sequence producer and the downstream decoder. Generates the
//  producer's clock-enable tick (replacing the divide-by-10 clock) and captures each completed
//  word on the rising edge of `sent`. Then clears the producer and queues the word in a small FIFO.
//  The FIFO drains to the decoder over a valid/ready handshake.
// PARAMETERS
//  DIV    10  clk cycles per prod_tick (>=2)
//  DEPTH  4   FIFO entries (power of 2, >=2)
//  WORD_W 10  width of outputbits word
// PORTS
//  clk          in   1                   system clock, single clock domain
//  Reset        in   1                   synchronous, active-high reset
//  outputbits   in   WORD_W              producer word
//  spa_end      in   1                   producer flag: 1=space word, 0=end-of-sequence
//  sent         in   1                   producer word-complete level; capture on rising edge
//  prod_tick    out  1                   1-cycle enable to producer every DIV clks
//  prod_clear   out  1                   clear request to producer, held one tick period
//  dec_valid    out  1                   FIFO head available
//  dec_ready    in   1                   decoder accepts head
//  dec_bits     out  WORD_W              FIFO head bits (first-word fall-through)
//  dec_spa_end  out  1                   FIFO head flag
//  fifo_count   out  $clog2(DEPTH+1)     occupancy
//  overflow     out  1                   sticky: a word was dropped while FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0, tick counter 0, FIFO empty, FSM IDLE, sent_q 0. Reset mid-word discards all.
//  Tick: counter 0..DIV-1; prod_tick=1 when counter==DIV-1, so the first tick is DIV cycles after reset.
//  Edge detect: sent_rise = sent & ~sent_q (sent_q registered each clk).
//  FSM IDLE: sent_rise -> push {spa_end,outputbits} (same cycle sampled); go CLEAR.
//  FSM CLEAR: prod_clear=1; on a cycle with prod_tick=1 go WAIT_LOW (clear seen by producer once).
//  FSM WAIT_LOW: prod_clear=0; when sent==0 go IDLE. A rise seen outside IDLE is ignored.
//  Push: accepted if count<DEPTH, or count==DEPTH with a pop in the same cycle (count unchanged).
//   Otherwise word dropped, overflow<=1 (cleared only by Reset); FSM still goes CLEAR.
//  Pop: dec_valid = (count!=0); pop when dec_valid & dec_ready. Outputs change the cycle after pop.
//  Simultaneous push+pop when not empty: count unchanged, order preserved. When empty, a push
//   makes dec_valid=1 the next cycle (no bypass; 1-cycle latency sent_rise -> dec_valid).
//  Pointers wrap modulo DEPTH; count saturates by construction, never exceeds DEPTH.
//  dec_bits/dec_spa_end are don't-care while dec_valid=0, but they are driven from the head register.
// CONFIGURATION
//  MORSE_SCHED_DROPCNT_EN defined: adds output drop_count[7:0], which increments on every dropped
//   word and saturates at 255. It is reset to 0. overflow is still present and = (drop_count!=0).
//  Not defined: port drop_count absent; only sticky overflow reported.
// STRUCTURE
//  morse_pkg: WORD_W default, symbol encodings (DOT/DASH/SPACE/END codes), FSM state typedef
//   {IDLE,CLEAR,WAIT_LOW}.
//  Sub-module morse_sync_fifo (DEPTH, WIDTH=WORD_W+1): sync FWFT FIFO with push/pop/count/full/empty.
//  Top: tick counter, edge detect, FSM, overflow/drop logic.
// TESTING
//  Reset release -> prod_tick first at cycle 10, then every 10; all other outputs 0.
//  sent 0->1 with bits=10'h2A5, spa_end=0, dec_ready=0 -> next cycle dec_valid=1, dec_bits=2A5,
//   count=1; prod_clear high until first prod_tick, then low.
//  Push 4 words with dec_ready=0, then a 5th -> count=4, overflow=1 (drop_count=1 if EN),
//   head still word 1.
//  Full FIFO, dec_ready=1 in same cycle as sent_rise -> push accepted, count stays 4, order w2..w5.
//  sent held high 30 cycles -> exactly one push; next push only after sent low then high.
//  Reset asserted in CLEAR with count=3 -> next cycle count=0, dec_valid=0, prod_clear=0, overflow=0.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared constants and types for the Morse word scheduler and its FIFO.
package morse_pkg;

    localparam int WORD_W_DEF = 10;

    typedef enum logic [1:0] {
        SYM_DOT   = 2'd0,
        SYM_DASH  = 2'd1,
        SYM_SPACE = 2'd2,
        SYM_END   = 2'd3
    } morse_sym_e;

    typedef logic [1:0] sched_state_t;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLEAR    = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;

endpackage

// File: rtl/morse_word_scheduler_if.sv
// Valid/ready channel carrying queued words from the scheduler to the decoder.
interface morse_word_scheduler_if
    import morse_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();

    logic              dec_valid;
    logic              dec_ready;
    logic [WORD_W-1:0] dec_bits;
    logic              dec_spa_end;

    modport master (output dec_valid, output dec_bits, output dec_spa_end, input dec_ready);
    modport slave  (input dec_valid, input dec_bits, input dec_spa_end, output dec_ready);

endinterface

// File: rtl/morse_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible on rdata_o.
module morse_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: state is updated with <= so every register samples pre-edge values.
    // NOTE: storage is reset too, so the head outputs read 0 after reset rather than stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/morse_word_scheduler.sv
// Producer tick generator, word capture FSM and decoder-side FIFO for the Morse chain.
// Define MORSE_SCHED_DROPCNT_EN to add a saturating drop_count output.
module morse_word_scheduler
    import morse_pkg::*;
#(
    parameter int DIV    = 10,
    parameter int DEPTH  = 4,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic [WORD_W-1:0]            outputbits,
    input  logic                         spa_end,
    input  logic                         sent,
    output logic                         prod_tick,
    output logic                         prod_clear,
    morse_word_scheduler_if.master       dec,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
`ifdef MORSE_SCHED_DROPCNT_EN
    ,
    output logic [7:0]                   drop_count
`endif
);

    localparam int TCNT_W = $clog2(DIV);

    logic [TCNT_W-1:0] tick_cnt_q;
    logic [TCNT_W-1:0] tick_cnt_d;
    logic              sent_q;
    sched_state_t      state_q;
    sched_state_t      state_d;

    logic              sent_rise;
    logic              push_req;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W:0]   fifo_head;

    assign prod_tick  = (tick_cnt_q == TCNT_W'(DIV-1));
    assign tick_cnt_d = prod_tick ? '0 : tick_cnt_q + 1'b1;

    assign sent_rise  = sent & ~sent_q;
    assign push_req   = (state_q == ST_IDLE) & sent_rise;
    assign pop        = dec.dec_valid & dec.dec_ready;
    assign drop       = push_req & fifo_full & ~pop;
    assign prod_clear = (state_q == ST_CLEAR);

    // NOTE: state_d takes its hold value first so no path through the case leaves it unassigned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (sent_rise) state_d = ST_CLEAR;
            ST_CLEAR:    if (prod_tick) state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!sent)     state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

`ifdef MORSE_SCHED_DROPCNT_EN
    logic [7:0] drop_cnt_q;
    logic [7:0] drop_cnt_d;

    assign drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    assign drop_count = drop_cnt_q;
    assign overflow   = (drop_cnt_q != 8'd0);
`else
    logic overflow_q;
    logic overflow_d;

    assign overflow_d = overflow_q | drop;
    assign overflow   = overflow_q;
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            tick_cnt_q <= '0;
            sent_q     <= 1'b0;
            state_q    <= ST_IDLE;
`ifdef MORSE_SCHED_DROPCNT_EN
            drop_cnt_q <= 8'd0;
`else
            overflow_q <= 1'b0;
`endif
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sent_q     <= sent;
            state_q    <= state_d;
`ifdef MORSE_SCHED_DROPCNT_EN
            drop_cnt_q <= drop_cnt_d;
`else
            overflow_q <= overflow_d;
`endif
        end
    end

    morse_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (Reset),
        .push_i  (push_req),
        .pop_i   (pop),
        .wdata_i ({spa_end, outputbits}),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign dec.dec_valid   = ~fifo_empty;
    assign dec.dec_spa_end = fifo_head[WORD_W];
    assign dec.dec_bits    = fifo_head[WORD_W-1:0];

endmodule

// File: tb/tb_morse_word_scheduler.sv
// Self-checking bench for morse_word_scheduler: directed table, corner sequences, random vs model.
module tb_morse_word_scheduler;
    import morse_pkg::*;

    localparam int DIV    = 10;
    localparam int DEPTH  = 4;
    localparam int WORD_W = 10;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              Reset = 1'b1;
    logic [WORD_W-1:0] outputbits = '0;
    logic              spa_end = 1'b0;
    logic              sent = 1'b0;
    logic              prod_tick;
    logic              prod_clear;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;
`ifdef MORSE_SCHED_DROPCNT_EN
    logic [7:0]        drop_count;
`endif

    int checks = 0;
    int errors = 0;

    morse_word_scheduler_if #(.WORD_W(WORD_W)) dec_if ();

    morse_word_scheduler #(
        .DIV    (DIV),
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .outputbits (outputbits),
        .spa_end    (spa_end),
        .sent       (sent),
        .prod_tick  (prod_tick),
        .prod_clear (prod_clear),
        .dec        (dec_if),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef MORSE_SCHED_DROPCNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: queue of {spa_end, bits}, cycle number since reset, capture phase.
    // Phase 0 = ready for a new word, 1 = clear requested, 2 = waiting for sent to drop.
    logic [WORD_W:0] m_q[$];
    int              m_n;
    bit              m_prev_sent;
    int              m_phase;
    bit              m_ovf;
    int              m_drops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        sent  = 1'b0;
        dec_if.dec_ready = 1'b0;
        @(posedge clk);
        #1;
        Reset       = 1'b0;
        m_q.delete();
        m_n         = 0;
        m_prev_sent = 1'b0;
        m_phase     = 0;
        m_ovf       = 1'b0;
        m_drops     = 0;
    endtask

    task automatic apply(input bit s, input logic [WORD_W-1:0] b, input bit sp, input bit rdy);
        bit tick_now;
        bit rise;
        bit pop;
        bit accept;
        bit dropped;
        sent             = s;
        outputbits       = b;
        spa_end          = sp;
        dec_if.dec_ready = rdy;
        tick_now = ((m_n % DIV) == DIV - 1);
        rise     = s && !m_prev_sent;
        pop      = (m_q.size() != 0) && rdy;
        accept   = (m_phase == 0) && rise && ((m_q.size() < DEPTH) || pop);
        dropped  = (m_phase == 0) && rise && !accept;
        if (pop) m_q.delete(0);
        if (accept) m_q.push_back({sp, b});
        if (dropped) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
        case (m_phase)
            0:       if (rise)     m_phase = 1;
            1:       if (tick_now) m_phase = 2;
            default: if (!s)       m_phase = 0;
        endcase
        m_prev_sent = s;
        m_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model();
        check("tick", 32'(prod_tick), 32'((m_n % DIV) == DIV - 1));
        check("clear", 32'(prod_clear), 32'(m_phase == 1));
        check("valid", 32'(dec_if.dec_valid), 32'(m_q.size() != 0));
        check("count", 32'(fifo_count), m_q.size());
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0)
            check("head", 32'({dec_if.dec_spa_end, dec_if.dec_bits}), 32'(m_q[0]));
`ifdef MORSE_SCHED_DROPCNT_EN
        check("drop_count", 32'(drop_count), m_drops);
`endif
    endtask

    typedef struct {
        bit              s;
        logic [WORD_W-1:0] b;
        bit              sp;
        bit              rdy;
        int              cyc;
        bit              e_valid;
        int              e_count;
        logic [WORD_W:0] e_head;
        bit              e_clear;
        bit              e_ovf;
        int              e_drops;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit rs;
        dec_if.dec_ready = 1'b0;

        // Reset values and tick cadence.
        do_reset();
        check("rst tick", 32'(prod_tick), 32'd0);
        check("rst clear", 32'(prod_clear), 32'd0);
        check("rst valid", 32'(dec_if.dec_valid), 32'd0);
        check("rst count", 32'(fifo_count), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst bits", 32'({dec_if.dec_spa_end, dec_if.dec_bits}), 32'd0);
        for (int i = 1; i <= 25; i++) begin
            apply(1'b0, '0, 1'b0, 1'b0);
            check($sformatf("tick cyc%0d", i), 32'(prod_tick), 32'((i % DIV) == DIV - 1));
        end

        // sent held high for 30 cycles captures a single word.
        do_reset();
        for (int i = 0; i < 30; i++) apply(1'b1, 10'h0AA, 1'b0, 1'b0);
        check("hold count", 32'(fifo_count), 32'd1);
        check("hold clear", 32'(prod_clear), 32'd0);
        apply(1'b0, 10'h0AA, 1'b0, 1'b0);
        apply(1'b1, 10'h155, 1'b1, 1'b0);
        check("repush count", 32'(fifo_count), 32'd2);
        check("repush clear", 32'(prod_clear), 32'd1);
        check("repush head", 32'({dec_if.dec_spa_end, dec_if.dec_bits}), 32'h0AA);

        // Fill, overflow, push-with-pop at full, drain.
        vecs.push_back('{1'b1, 10'h2A5, 1'b0, 1'b0,  1, 1'b1, 1, 11'h2A5, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b0, 12, 1'b1, 1, 11'h2A5, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 10'h155, 1'b1, 1'b0,  1, 1'b1, 2, 11'h2A5, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b0, 12, 1'b1, 2, 11'h2A5, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 10'h3FF, 1'b0, 1'b0,  1, 1'b1, 3, 11'h2A5, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b0, 12, 1'b1, 3, 11'h2A5, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 10'h001, 1'b1, 1'b0,  1, 1'b1, 4, 11'h2A5, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b0, 12, 1'b1, 4, 11'h2A5, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 10'h0F0, 1'b0, 1'b0,  1, 1'b1, 4, 11'h2A5, 1'b1, 1'b1, 1});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b0, 12, 1'b1, 4, 11'h2A5, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b1, 10'h30C, 1'b1, 1'b1,  1, 1'b1, 4, 11'h555, 1'b1, 1'b1, 1});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b0, 12, 1'b1, 4, 11'h555, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b1,  1, 1'b1, 3, 11'h3FF, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b1,  1, 1'b1, 2, 11'h401, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b1,  1, 1'b1, 1, 11'h70C, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 10'h000, 1'b0, 1'b1,  1, 1'b0, 0, 11'h000, 1'b0, 1'b1, 1});

        do_reset();
        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].cyc; c++) begin
                apply(vecs[i].s, vecs[i].b, vecs[i].sp, vecs[i].rdy);
                compare_model();
            end
            check($sformatf("vec%0d valid", i), 32'(dec_if.dec_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d count", i), 32'(fifo_count), vecs[i].e_count);
            check($sformatf("vec%0d clear", i), 32'(prod_clear), 32'(vecs[i].e_clear));
            check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            if (vecs[i].e_valid)
                check($sformatf("vec%0d head", i), 32'({dec_if.dec_spa_end, dec_if.dec_bits}),
                      32'(vecs[i].e_head));
`ifdef MORSE_SCHED_DROPCNT_EN
            check($sformatf("vec%0d drops", i), 32'(drop_count), vecs[i].e_drops);
`endif
        end

        // Reset while clearing with three words queued and overflow set.
        for (int w = 0; w < 3; w++) begin
            apply(1'b1, 10'(w + 1), 1'b0, 1'b0);
            if (w < 2) for (int c = 0; c < 12; c++) apply(1'b0, '0, 1'b0, 1'b0);
        end
        check("pre-rst count", 32'(fifo_count), 32'd3);
        check("pre-rst clear", 32'(prod_clear), 32'd1);
        check("pre-rst overflow", 32'(overflow), 32'd1);
        do_reset();
        check("mid-rst count", 32'(fifo_count), 32'd0);
        check("mid-rst valid", 32'(dec_if.dec_valid), 32'd0);
        check("mid-rst clear", 32'(prod_clear), 32'd0);
        check("mid-rst overflow", 32'(overflow), 32'd0);
        check("mid-rst tick", 32'(prod_tick), 32'd0);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        rs = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            bit rdy;
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                rs = 1'b0;
                compare_model();
            end else begin
                if ($urandom_range(0, 5) == 0) rs = !rs;
                if (((k / 200) % 2) == 0) rdy = ($urandom_range(0, 3) == 0);
                else                      rdy = ($urandom_range(0, 1) == 1);
                apply(rs, WORD_W'($urandom), ($urandom_range(0, 1) == 1), rdy);
                compare_model();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
